vend_coin_sequencer: RTL and testbench

- Controller in front of the vending_machine core (balance/open datapath).
- Collects coin pulses from N_SLOTS physical coin slots and queues them per slot.
- Serializes coins round-robin into the core's single nickel/dime input, refunds overpayment, runs the dispense handshake, then clears the core for the next sale.

---
 rtl/vend_coin_sequencer_if.sv | 34 +++
 rtl/vend_coin_sequencer.sv | 165 ++++++++++++++++
 tb/tb_vend_coin_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/vend_coin_sequencer_if.sv
// Bundle between the coin sequencer and its surroundings. This includes the
// coin slots, the vending_machine core and the dispense mechanism.
//   master : the sequencer. It drives the core controls, refunds, dispense
//            request and status.
//   slave  : the environment. It drives the slot pulses, the core status and
//            the dispense ack.
interface vend_coin_sequencer_if #(
    parameter int N_SLOTS = 2
);
    logic [N_SLOTS-1:0] slot_nickel;   // per-slot 5c pulse
    logic [N_SLOTS-1:0] slot_dime;     // per-slot 10c pulse
    logic [N_SLOTS-1:0] coin_reject;   // per-slot queue-full drop pulse
    logic               vm_nickel;     // core: add 5
    logic               vm_dime;       // core: add 10
    logic               vm_reset;      // core: synchronous clear
    logic [3:0]         vm_balance;    // core: 0/5/10/15
    logic               vm_open;       // core: balance reached 15
    logic               change_nickel; // return 5c to customer
    logic               dispense_req;  // level request to mechanism
    logic               dispense_ack;  // mechanism done
    logic               busy;          // not in ACCEPT

    modport master (
        input  slot_nickel, slot_dime, vm_balance, vm_open, dispense_ack,
        output coin_reject, vm_nickel, vm_dime, vm_reset, change_nickel,
               dispense_req, busy
    );

    modport slave (
        output slot_nickel, slot_dime, vm_balance, vm_open, dispense_ack,
        input  coin_reject, vm_nickel, vm_dime, vm_reset, change_nickel,
               dispense_req, busy
    );
endinterface

// File: rtl/vend_coin_sequencer.sv
// Coin sequencer in front of the vending_machine core.
// Each slot has its own pending-coin counters. Queued coins are forwarded one
// at a time, round-robin, into the core's single nickel/dime input. A dime
// that would overshoot 15 causes a nickel to be refunded. When the core opens,
// the block runs the dispense handshake and then clears the core.
//
// vend_coin_slot_q ports (one instance per slot):
//   clk, reset              clock, synchronous active-high reset
//   nickel_i, dime_i        coin pulses from the slot
//   take_nickel_i/_dime_i   coin of that type forwarded this cycle
//   nick_cnt_o, dime_cnt_o  pending counts
//   reject_o                registered pulse: a coin was dropped (queue full)
// vend_coin_sequencer ports:
//   clk, reset              clock, synchronous active-high reset
//   bus                     vend_coin_sequencer_if.master (see interface file)

module vend_coin_slot_q #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             nickel_i,
    input  logic             dime_i,
    input  logic             take_nickel_i,
    input  logic             take_dime_i,
    output logic [CNT_W-1:0] nick_cnt_o,
    output logic [CNT_W-1:0] dime_cnt_o,
    output logic             reject_o
);
    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] nick_q, nick_d, dime_q, dime_d;
    logic             rej_q, rej_d;

    // An insert and a take in the same cycle cancel each other. This lets a
    // full counter accept a coin in the very cycle it forwards one.
    always_comb begin
        nick_d = nick_q;
        dime_d = dime_q;
        rej_d  = 1'b0;
        if (nickel_i && !take_nickel_i) begin
            if (nick_q == MAX) rej_d  = 1'b1;
            else               nick_d = nick_q + CNT_W'(1);
        end else if (!nickel_i && take_nickel_i) begin
            nick_d = nick_q - CNT_W'(1);
        end
        if (dime_i && !take_dime_i) begin
            if (dime_q == MAX) rej_d  = 1'b1;
            else               dime_d = dime_q + CNT_W'(1);
        end else if (!dime_i && take_dime_i) begin
            dime_d = dime_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nick_q <= '0;
            dime_q <= '0;
            rej_q  <= 1'b0;
        end else begin
            nick_q <= nick_d;
            dime_q <= dime_d;
            rej_q  <= rej_d;
        end
    end

    assign nick_cnt_o = nick_q;
    assign dime_cnt_o = dime_q;
    assign reject_o   = rej_q;
endmodule

module vend_coin_sequencer #(
    parameter int N_SLOTS = 2,
    parameter int CNT_W   = 2
) (
    input logic                   clk,
    input logic                   reset,
    vend_coin_sequencer_if.master bus
);
    localparam int PTR_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    typedef enum logic [1:0] {ACCEPT, SETTLE, VEND, CLEAR} state_t;

    state_t                          state_q, state_d;
    logic [PTR_W-1:0]                ptr_q, ptr_d;
    logic [N_SLOTS-1:0][CNT_W-1:0]   nick_cnt, dime_cnt;
    logic [N_SLOTS-1:0]              pending;
    logic [N_SLOTS-1:0]              take_n, take_d;
    logic [PTR_W-1:0]                gnt;
    logic                            found;
    logic                            fwd_n, fwd_d;
    int unsigned                     idx;

    for (genvar s = 0; s < N_SLOTS; s++) begin : g_slot
        assign take_n[s]  = fwd_n && (gnt == PTR_W'(s));
        assign take_d[s]  = fwd_d && (gnt == PTR_W'(s));
        assign pending[s] = (nick_cnt[s] != '0) || (dime_cnt[s] != '0);

        vend_coin_slot_q #(.CNT_W(CNT_W)) u_q (
            .clk          (clk),
            .reset        (reset),
            .nickel_i     (bus.slot_nickel[s]),
            .dime_i       (bus.slot_dime[s]),
            .take_nickel_i(take_n[s]),
            .take_dime_i  (take_d[s]),
            .nick_cnt_o   (nick_cnt[s]),
            .dime_cnt_o   (dime_cnt[s]),
            .reject_o     (bus.coin_reject[s])
        );
    end

    // Round-robin search: the first slot with a pending coin, scanning from the pointer.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int i = 0; i < N_SLOTS; i++) begin
            idx = (int'(ptr_q) + i) % N_SLOTS;
            if (!found && pending[idx]) begin
                found = 1'b1;
                gnt   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        fwd_n   = 1'b0;
        fwd_d   = 1'b0;
        case (state_q)
            ACCEPT: if (found && !reset) begin
                // Within the granted slot, a dime beats a nickel.
                fwd_d   = (dime_cnt[gnt] != '0);
                fwd_n   = !fwd_d;
                ptr_d   = (int'(gnt) == N_SLOTS - 1) ? '0 : gnt + PTR_W'(1);
                state_d = SETTLE;
            end
            // Spend one cycle here so that vm_open reflects the coin just
            // forwarded. This keeps any coin from reaching a core at 15.
            SETTLE:  state_d = bus.vm_open ? VEND : ACCEPT;
            VEND:    if (bus.dispense_ack) state_d = CLEAR;
            CLEAR:   state_d = ACCEPT;
            default: state_d = ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCEPT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.vm_nickel     = fwd_n;
    assign bus.vm_dime       = fwd_d;
    // The core saturates at 15, so a dime on top of 10 overpays by 5c.
    assign bus.change_nickel = fwd_d && (bus.vm_balance == 4'd10);
    assign bus.vm_reset      = reset || (state_q == CLEAR);
    assign bus.dispense_req  = (state_q == VEND);
    assign bus.busy          = (state_q != ACCEPT);
endmodule

// File: tb/tb_vend_coin_sequencer.sv
module tb_vend_coin_sequencer;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [3:0] bal;

    vend_coin_sequencer_if #(.N_SLOTS(2)) bus ();

    vend_coin_sequencer #(.N_SLOTS(2), .CNT_W(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the vending_machine core.
    always_ff @(posedge clk) begin
        if (bus.vm_reset)       bal <= 4'd0;
        else if (bus.vm_dime)   bal <= (bal >= 4'd5) ? 4'd15 : bal + 4'd10;
        else if (bus.vm_nickel) bal <= (bal == 4'd15) ? 4'd15 : bal + 4'd5;
    end
    assign bus.vm_balance = bal;
    assign bus.vm_open    = (bal == 4'd15);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge and drop the one-cycle pulses.
    task automatic step();
        @(posedge clk);
        #1;
        bus.slot_nickel = '0;
        bus.slot_dime   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        bus.slot_nickel = '0;
        bus.slot_dime = '0;
        bus.dispense_ack = 1'b0;
        step();
        step();
        chk("rst vm_reset", 32'(bus.vm_reset), 1);
        chk("rst dispense_req", 32'(bus.dispense_req), 0);
        chk("rst vm_nickel", 32'(bus.vm_nickel), 0);
        chk("rst vm_dime", 32'(bus.vm_dime), 0);
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst coin_reject", 32'(bus.coin_reject), 0);
        reset = 1'b0;
        step();
        chk("rst released vm_reset", 32'(bus.vm_reset), 0);
        chk("rst balance", 32'(bus.vm_balance), 0);

        // Basic sale: a dime followed by a nickel, then the dispense handshake and clear.
        bus.slot_dime = 2'b01;
        step();
        chk("t1 vm_dime", 32'(bus.vm_dime), 1);
        chk("t1 no nickel yet", 32'(bus.vm_nickel), 0);
        bus.slot_nickel = 2'b01;
        step();
        chk("t1 settle busy", 32'(bus.busy), 1);
        chk("t1 settle vm_nickel", 32'(bus.vm_nickel), 0);
        chk("t1 balance10", 32'(bus.vm_balance), 10);
        step();
        chk("t1 vm_nickel", 32'(bus.vm_nickel), 1);
        chk("t1 no change", 32'(bus.change_nickel), 0);
        step();
        chk("t1 vm_open", 32'(bus.vm_open), 1);
        step();
        chk("t1 dispense_req", 32'(bus.dispense_req), 1);
        step();
        chk("t1 dispense_req hold", 32'(bus.dispense_req), 1);
        bus.dispense_ack = 1'b1;
        step();
        chk("t1 clear vm_reset", 32'(bus.vm_reset), 1);
        chk("t1 clear dispense_req", 32'(bus.dispense_req), 0);
        bus.dispense_ack = 1'b0;
        step();
        chk("t1 vm_reset one cycle", 32'(bus.vm_reset), 0);
        chk("t1 balance0", 32'(bus.vm_balance), 0);
        chk("t1 busy0", 32'(bus.busy), 0);

        // Round-robin order. A slot0 nickel and a slot1 dime arrive together
        // with the pointer at 0, so the nickel (slot0) goes first.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            bus.slot_nickel = 2'b01;
            bus.slot_dime   = 2'b10;
            step();
            chk("t2 slot0 first", 32'({bus.vm_dime, bus.vm_nickel}), 32'h1);
            step();
            step();
            chk("t2 slot1 second", 32'({bus.vm_dime, bus.vm_nickel}), 32'h2);
            chk("t2 change at 5", 32'(bus.change_nickel), 0);
            step();
            step();
            chk("t2 vend", 32'(bus.dispense_req), 1);
            bus.dispense_ack = 1'b1;
            step();
            bus.dispense_ack = 1'b0;
            step();
            chk("t2 idle", 32'(bus.busy), 0);
        end
        // Fairness: a grant to slot1 alone wraps the pointer back to slot0.
        bus.slot_dime = 2'b10;
        step();
        chk("t2 slot1 alone", 32'(bus.vm_dime), 1);
        step();
        step();
        chk("t2 idle after single", 32'({bus.vm_dime, bus.vm_nickel}), 0);
        bus.slot_nickel = 2'b01;
        bus.slot_dime   = 2'b10;
        step();
        chk("t2 ptr wrapped slot0", 32'({bus.vm_dime, bus.vm_nickel}), 32'h1);
        step();
        step();
        chk("t2 vend at 15", 32'(bus.dispense_req), 1);
        bus.dispense_ack = 1'b1;
        step();
        bus.dispense_ack = 1'b0;
        step();
        chk("t2 leftover slot1 dime", 32'(bus.vm_dime), 1);
        chk("t2 no change at 0", 32'(bus.change_nickel), 0);
        step();
        step();
        chk("t2 balance10 idle", 32'(bus.vm_balance), 10);

        // A dime on top of a balance of 10 refunds a nickel.
        bus.slot_dime = 2'b10;
        step();
        chk("t3 vm_dime", 32'(bus.vm_dime), 1);
        chk("t3 change_nickel", 32'(bus.change_nickel), 1);
        step();
        chk("t3 settle", 32'(bus.busy), 1);
        step();
        chk("t3 vend", 32'(bus.dispense_req), 1);

        // While ack is held low, the slot0 nickel queue fills (3 deep) and rejects the 4th coin.
        for (int i = 0; i < 4; i++) begin
            bus.slot_nickel = 2'b01;
            step();
            chk("t4 reject", 32'(bus.coin_reject), (i == 3) ? 32'h1 : 32'h0);
            chk("t4 no forward in vend", 32'({bus.vm_dime, bus.vm_nickel}), 0);
            step();
        end
        chk("t4 reject one cycle", 32'(bus.coin_reject), 0);
        repeat (12) step();
        chk("t4 still vend", 32'(bus.dispense_req), 1);
        bus.dispense_ack = 1'b1;
        step();
        bus.dispense_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4 nickel fwd", 32'(bus.vm_nickel), 1);
            step();
            chk("t4 gap", 32'(bus.vm_nickel), 0);
        end
        step();
        chk("t4 vend after 3 nickels", 32'(bus.dispense_req), 1);
        bus.dispense_ack = 1'b1;
        step();
        bus.dispense_ack = 1'b0;
        step();
        chk("t4 idle", 32'(bus.busy), 0);

        // Nickel and dime from the same slot in one cycle: the dime goes first.
        bus.slot_nickel = 2'b01;
        bus.slot_dime   = 2'b01;
        step();
        chk("t5 dime first", 32'({bus.vm_dime, bus.vm_nickel}), 32'h2);
        step();
        step();
        chk("t5 nickel next", 32'({bus.vm_dime, bus.vm_nickel}), 32'h1);
        step();
        chk("t5 open", 32'(bus.vm_open), 1);
        step();
        chk("t5 vend", 32'(bus.dispense_req), 1);

        // Reset during VEND with a coin queued.
        bus.slot_dime = 2'b10;
        step();
        reset = 1'b1;
        #1;
        chk("t6 vm_reset with reset", 32'(bus.vm_reset), 1);
        step();
        chk("t6 dispense_req dropped", 32'(bus.dispense_req), 0);
        chk("t6 busy", 32'(bus.busy), 0);
        reset = 1'b0;
        step();
        chk("t6 queued coin lost", 32'({bus.vm_dime, bus.vm_nickel}), 0);
        chk("t6 balance cleared", 32'(bus.vm_balance), 0);
        step();
        chk("t6 still nothing", 32'({bus.vm_dime, bus.vm_nickel}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
